// File: rtl/pkg_tpu.sv
// Shared TPU data-memory types: load descriptor, address, handshake and load-FSM encodings.
package pkg_tpu;

    localparam int unsigned WIDTH_SIZE_DMEM = 10;

    typedef logic [WIDTH_SIZE_DMEM-1:0] address_t;
    typedef logic                       s_ready_t;
    typedef logic                       s_grant_t;

    typedef struct packed {
        logic     req;
        address_t len;
        address_t stride;
        address_t base;
    } dmem_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        WAIT   = 2'd1,
        RUN    = 2'd2,
        NOTIFY = 2'd3
    } fsm_extern_ld_t;

endpackage

// File: rtl/dmem_ld_agu_if.sv
// Load-AGU bus bundle: descriptor in, arbiter handshake, memory address stream, completion.
interface dmem_ld_agu_if;
    import pkg_tpu::*;

    dmem_t    I_Ld;
    logic     O_Busy;
    logic     O_Arb_Req;
    s_grant_t I_Grant;
    logic     O_Mem_Req;
    address_t O_Mem_Addr;
    s_ready_t I_Mem_Ready;
    logic     O_Last;
    logic     O_Done;
    logic     O_Err;

    // AGU side
    modport master (
        input  I_Ld, I_Grant, I_Mem_Ready,
        output O_Busy, O_Arb_Req, O_Mem_Req, O_Mem_Addr, O_Last, O_Done, O_Err
    );

    // Execute stage / arbiter / memory side
    modport slave (
        output I_Ld, I_Grant, I_Mem_Ready,
        input  O_Busy, O_Arb_Req, O_Mem_Req, O_Mem_Addr, O_Last, O_Done, O_Err
    );

endinterface

// File: rtl/dmem_ld_agu.sv
// Strided load address generator: captures a descriptor, arbitrates for the data
// memory, emits one word address per accepted beat and pulses O_Done at the end.
// Optional feature macro: DMEM_AGU_WRAP_CHK_EN (flag address overflow as a sticky error).
module dmem_ld_agu
    import pkg_tpu::*;
#(
    parameter int unsigned WIDTH_ADDR = WIDTH_SIZE_DMEM
) (
    input  logic          clock,
    input  logic          reset,
    dmem_ld_agu_if.master ld
);

    fsm_extern_ld_t        state_q, state_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_ADDR-1:0] stride_q, stride_d;
    logic [WIDTH_ADDR-1:0] rem_q, rem_d;

    logic busy_q, busy_d;
    logic arb_q, arb_d;
    logic mem_req_q, mem_req_d;
    logic last_q, last_d;
    logic done_q, done_d;

`ifdef DMEM_AGU_WRAP_CHK_EN
    logic                  err_q, err_d;
    logic [WIDTH_ADDR:0]   sum_c;
    assign sum_c = {1'b0, addr_q} + {1'b0, stride_q};
`else
    logic [WIDTH_ADDR-1:0] sum_c;
    assign sum_c = addr_q + stride_q;
`endif

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        rem_d    = rem_q;
`ifdef DMEM_AGU_WRAP_CHK_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            INIT: begin
                if (ld.I_Ld.req) begin
                    addr_d   = WIDTH_ADDR'(ld.I_Ld.base);
                    stride_d = WIDTH_ADDR'(ld.I_Ld.stride);
                    rem_d    = WIDTH_ADDR'(ld.I_Ld.len);
`ifdef DMEM_AGU_WRAP_CHK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = (ld.I_Ld.len == '0) ? NOTIFY : WAIT;
                end
            end
            WAIT: begin
                if (ld.I_Grant) state_d = RUN;
            end
            RUN: begin
                if (ld.I_Mem_Ready) begin
                    if (rem_q == WIDTH_ADDR'(1)) begin
                        addr_d  = sum_c[WIDTH_ADDR-1:0];
                        rem_d   = rem_q - WIDTH_ADDR'(1);
                        state_d = NOTIFY;
                    end
`ifdef DMEM_AGU_WRAP_CHK_EN
                    // Overflowing address is never loaded, so it is never issued
                    else if (sum_c[WIDTH_ADDR]) begin
                        err_d   = 1'b1;
                        state_d = NOTIFY;
                    end
`endif
                    else begin
                        addr_d = sum_c[WIDTH_ADDR-1:0];
                        rem_d  = rem_q - WIDTH_ADDR'(1);
                    end
                end
            end
            NOTIFY: begin
                state_d = INIT;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        busy_d    = (state_d != INIT);
        arb_d     = (state_d == WAIT) || (state_d == RUN);
        mem_req_d = (state_d == RUN);
        last_d    = (state_d == RUN) && (rem_d == WIDTH_ADDR'(1));
        done_d    = (state_d == NOTIFY);
    end

    // State, datapath and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            addr_q    <= '0;
            stride_q  <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            arb_q     <= 1'b0;
            mem_req_q <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            arb_q     <= arb_d;
            mem_req_q <= mem_req_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

`ifdef DMEM_AGU_WRAP_CHK_EN
    // Sticky wrap error, cleared by the next accepted descriptor
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign ld.O_Err = err_q;
`else
    assign ld.O_Err = 1'b0;
`endif

    assign ld.O_Busy     = busy_q;
    assign ld.O_Arb_Req  = arb_q;
    assign ld.O_Mem_Req  = mem_req_q;
    assign ld.O_Mem_Addr = address_t'(addr_q);
    assign ld.O_Last     = last_q;
    assign ld.O_Done     = done_q;

endmodule

// File: tb/tb_dmem_ld_agu.sv
// Directed bench for dmem_ld_agu: table of bursts plus stall, ignored-request and reset sequences.
module tb_dmem_ld_agu;
    import pkg_tpu::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    dmem_ld_agu_if ld_if ();

    dmem_ld_agu #(.WIDTH_ADDR(10)) dut (
        .clock (clk),
        .reset (rst_n),
        .ld    (ld_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]      base;
        logic [9:0]      stride;
        logic [9:0]      len;
        int              exp_beats;
        logic [0:3][9:0] exp_a;
        int              exp_done;
        logic            exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [9:0] base, input logic [9:0] stride, input logic [9:0] len);
        ld_if.I_Ld.req    = 1'b1;
        ld_if.I_Ld.base   = base;
        ld_if.I_Ld.stride = stride;
        ld_if.I_Ld.len    = len;
    endtask

    // Runs one burst with grant and ready held high; checks addresses, last, done cycle and error.
    task automatic run_burst(input string nm, input vec_t v);
        int nb;
        int arb_cnt;
        int dcyc;
        bit seen_done;
        issue(v.base, v.stride, v.len);
        tick();
        ld_if.I_Ld.req = 1'b0;
        chk({nm, " busy_t1"}, 32'(ld_if.O_Busy), 32'd1);
        chk({nm, " err_clear"}, 32'(ld_if.O_Err), 32'd0);
        nb = 0; arb_cnt = 0; dcyc = 0; seen_done = 1'b0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            if (ld_if.O_Arb_Req) arb_cnt++;
            if (ld_if.O_Mem_Req) begin
                chk({nm, " last"}, 32'(ld_if.O_Last), 32'(nb == int'(v.len) - 1));
                if (nb < 4) chk({nm, " addr"}, 32'(ld_if.O_Mem_Addr), 32'(v.exp_a[nb]));
                nb++;
            end
            if (ld_if.O_Done) begin
                seen_done = 1'b1;
                dcyc = c;
                chk({nm, " err"}, 32'(ld_if.O_Err), 32'(v.exp_err));
            end else begin
                tick();
            end
        end
        chk({nm, " done_cycle"}, 32'(dcyc), 32'(v.exp_done));
        chk({nm, " beats"}, 32'(nb), 32'(v.exp_beats));
        chk({nm, " arb_cycles"}, 32'(arb_cnt), (v.len == 10'd0) ? 32'd0 : 32'(v.exp_done - 1));
        tick();
        chk({nm, " idle_busy"}, 32'(ld_if.O_Busy), 32'd0);
        chk({nm, " idle_done"}, 32'(ld_if.O_Done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb;
        int   stalls;
        int   dcyc;
        int   done_cnt;
        logic [9:0] seq[$];
        logic [9:0] exp_seq[$];
        vec_t v;

        errors = 0;
        checks = 0;

        vecs[0] = '{base:10'h010, stride:10'h004, len:10'd3, exp_beats:3,
                    exp_a:'{10'h010, 10'h014, 10'h018, 10'h000}, exp_done:5, exp_err:1'b0};
`ifdef DMEM_AGU_WRAP_CHK_EN
        vecs[1] = '{base:10'h3FC, stride:10'h008, len:10'd2, exp_beats:1,
                    exp_a:'{10'h3FC, 10'h000, 10'h000, 10'h000}, exp_done:3, exp_err:1'b1};
`else
        vecs[1] = '{base:10'h3FC, stride:10'h008, len:10'd2, exp_beats:2,
                    exp_a:'{10'h3FC, 10'h004, 10'h000, 10'h000}, exp_done:4, exp_err:1'b0};
`endif
        vecs[2] = '{base:10'h3FF, stride:10'h001, len:10'd1, exp_beats:1,
                    exp_a:'{10'h3FF, 10'h000, 10'h000, 10'h000}, exp_done:3, exp_err:1'b0};
        vecs[3] = '{base:10'h100, stride:10'h000, len:10'd3, exp_beats:3,
                    exp_a:'{10'h100, 10'h100, 10'h100, 10'h000}, exp_done:5, exp_err:1'b0};
        vecs[4] = '{base:10'h000, stride:10'h3FF, len:10'd2, exp_beats:2,
                    exp_a:'{10'h000, 10'h3FF, 10'h000, 10'h000}, exp_done:4, exp_err:1'b0};
        vecs[5] = '{base:10'h055, stride:10'h001, len:10'd0, exp_beats:0,
                    exp_a:'{10'h000, 10'h000, 10'h000, 10'h000}, exp_done:1, exp_err:1'b0};
        vecs[6] = '{base:10'h2F0, stride:10'h040, len:10'd4, exp_beats:4,
                    exp_a:'{10'h2F0, 10'h330, 10'h370, 10'h3B0}, exp_done:6, exp_err:1'b0};

        // Reset state
        rst_n = 1'b0;
        ld_if.I_Ld = '0;
        ld_if.I_Grant = 1'b1;
        ld_if.I_Mem_Ready = 1'b1;
        tick();
        tick();
        chk("reset busy", 32'(ld_if.O_Busy), 32'd0);
        chk("reset arb", 32'(ld_if.O_Arb_Req), 32'd0);
        chk("reset mem_req", 32'(ld_if.O_Mem_Req), 32'd0);
        chk("reset addr", 32'(ld_if.O_Mem_Addr), 32'd0);
        chk("reset done", 32'(ld_if.O_Done), 32'd0);
        chk("reset err", 32'(ld_if.O_Err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven bursts, back-to-back
        for (int i = 0; i < 7; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i]);
        end

        // Delayed grant (3 cycles late) and 2-cycle stall on the second beat
        ld_if.I_Grant = 1'b0;
        issue(10'h010, 10'h004, 10'd3);
        tick();
        ld_if.I_Ld.req = 1'b0;
        nb = 0; stalls = 0; dcyc = 0; done_cnt = 0;
        seq.delete();
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) chk("stall wait_no_mem", 32'(ld_if.O_Mem_Req), 32'd0);
            if (c == 2) chk("stall wait_arb", 32'(ld_if.O_Arb_Req), 32'd1);
            ld_if.I_Grant = (c >= 4);
            ld_if.I_Mem_Ready = 1'b1;
            if (ld_if.O_Mem_Req) begin
                seq.push_back(ld_if.O_Mem_Addr);
                if (nb == 1 && stalls < 2) begin
                    ld_if.I_Mem_Ready = 1'b0;
                    stalls++;
                end else begin
                    nb++;
                end
            end
            if (ld_if.O_Done) begin
                done_cnt++;
                if (dcyc == 0) dcyc = c;
            end
            tick();
        end
        ld_if.I_Grant = 1'b1;
        ld_if.I_Mem_Ready = 1'b1;
        exp_seq = '{10'h010, 10'h014, 10'h014, 10'h014, 10'h018};
        chk("stall beat_cycles", 32'(seq.size()), 32'(exp_seq.size()));
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) chk($sformatf("stall addr%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        end
        chk("stall done_cycle", 32'(dcyc), 32'd10);
        chk("stall done_count", 32'(done_cnt), 32'd1);

        // Second request during RUN must be ignored
        issue(10'h200, 10'h002, 10'd4);
        tick();
        ld_if.I_Ld.req = 1'b0;
        seq.delete();
        dcyc = 0;
        for (int c = 1; c <= 12 && dcyc == 0; c++) begin
            if (ld_if.O_Mem_Req) seq.push_back(ld_if.O_Mem_Addr);
            if (ld_if.O_Done) dcyc = c;
            if (c == 2) issue(10'h050, 10'h000, 10'd1);
            else        ld_if.I_Ld.req = 1'b0;
            if (dcyc == 0) tick();
        end
        ld_if.I_Ld.req = 1'b0;
        exp_seq = '{10'h200, 10'h202, 10'h204, 10'h206};
        chk("ignore beat_count", 32'(seq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seq.size()) chk($sformatf("ignore addr%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        end
        chk("ignore done_cycle", 32'(dcyc), 32'd6);
        tick();
        chk("ignore idle_busy", 32'(ld_if.O_Busy), 32'd0);

        // Reset in the middle of a burst
        issue(10'h080, 10'h010, 10'd5);
        tick();
        ld_if.I_Ld.req = 1'b0;
        tick();
        tick();
        chk("rstmid addr_before", 32'(ld_if.O_Mem_Addr), 32'h090);
        rst_n = 1'b0;
        #1;
        chk("rstmid busy", 32'(ld_if.O_Busy), 32'd0);
        chk("rstmid arb", 32'(ld_if.O_Arb_Req), 32'd0);
        chk("rstmid mem_req", 32'(ld_if.O_Mem_Req), 32'd0);
        chk("rstmid addr", 32'(ld_if.O_Mem_Addr), 32'd0);
        chk("rstmid last", 32'(ld_if.O_Last), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ld_if.O_Done) done_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (ld_if.O_Done) done_cnt++;
        end
        chk("rstmid no_done", 32'(done_cnt), 32'd0);
        chk("rstmid idle_busy", 32'(ld_if.O_Busy), 32'd0);
        v = '{base:10'h123, stride:10'h001, len:10'd2, exp_beats:2,
              exp_a:'{10'h123, 10'h124, 10'h000, 10'h000}, exp_done:4, exp_err:1'b0};
        run_burst("post_reset", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ld_agu.md
# dmem_ld_agu

Load address-generation unit for the TPU data memory. It accepts a strided load descriptor (`dmem_t`: req/len/stride/base) from the execution stage and arbitrates for data-memory access. Once granted, it emits one word address per accepted beat. When the burst is complete it signals completion to the scalar/vector pipeline. One instance sits between each lane's execution stage and the data-memory port, directly downstream of the load descriptor produced by the execute stage.

## Interface
Parameters:
- `WIDTH_ADDR`, default `WIDTH_SIZE_DMEM` (10): address, length and stride width.

Ports:
- `clock`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `I_Ld`: input, `dmem_t`. Load descriptor; `I_Ld.req` is the request strobe.
- `O_Busy`: output, 1 bit. High in any state other than INIT.
- `O_Arb_Req`: output, 1 bit. Request to the data-memory arbiter.
- `I_Grant`: input, `s_grant_t`. Arbiter grant, sampled in WAIT.
- `O_Mem_Req`: output, 1 bit. Address valid.
- `O_Mem_Addr`: output, `address_t`. Current word address.
- `I_Mem_Ready`: input, `s_ready_t`. Memory accepts the beat when `O_Mem_Req & I_Mem_Ready`.
- `O_Last`: output, 1 bit. Current beat is the final one.
- `O_Done`: output, 1 bit. One-cycle completion pulse.
- `O_Err`: output, 1 bit. Wrap error; see Configuration.

## Operation
- FSM uses `fsm_extern_ld_t`: INIT, WAIT, RUN, NOTIFY.
- INIT:
  - If `I_Ld.req` is high, capture base/stride/len into the address register, stride register and remaining-count register.
  - If len==0, go to NOTIFY; otherwise go to WAIT.
  - `I_Ld.req` is ignored in every other state; the descriptor is dropped, and the upstream stage must hold off while `O_Busy` is high.
- WAIT:
  - `O_Arb_Req`=1.
  - On `I_Grant`=1, go to RUN.
- RUN:
  - `O_Arb_Req`=1 and `O_Mem_Req`=1; `O_Mem_Addr` = address register.
  - On each accepted beat: address <= address + stride, truncated to `WIDTH_ADDR` (modulo 1024 wrap), and remaining <= remaining − 1.
  - `O_Last` = (remaining==1).
  - The accepted beat with `O_Last` goes to NOTIFY.
  - `I_Grant` is not re-checked in RUN; the arbiter must hold the grant until `O_Arb_Req` falls.
- NOTIFY:
  - `O_Done`=1 for exactly one cycle, then go to INIT.
- Stride is an unsigned `WIDTH_ADDR` value. Stride 0 repeats the base address len times.
- len field maximum is 1023 beats.

## Timing
- Reset (asynchronous, `reset`=0):
  - State goes to INIT.
  - All registers and all outputs are 0; `O_Err` is cleared.
  - A reset mid-burst abandons the burst without `O_Done`.
- Latencies:
  - Req in INIT at cycle t puts the FSM in WAIT at t+1. If grant is present at t+1, the FSM is in RUN at t+2 and the first address is on `O_Mem_Addr` at t+2.
  - With `I_Mem_Ready` held high, the block issues one beat per cycle. An N-beat burst occupies RUN for N cycles, and `O_Done` is at t+2+N.
  - `I_Mem_Ready`=0 stalls the burst; address and count hold.
  - len==0: `O_Done` at t+1 with no arbiter or memory traffic.
- Back-to-back: the earliest new request is accepted in the cycle after NOTIFY, when the FSM is back in INIT.
- Outputs are registered-state decodes only. There is no combinational path from `I_Mem_Ready` or `I_Grant` to any output.

## Configuration
- `DMEM_AGU_WRAP_CHK_EN` defined:
  - If address + stride overflows `WIDTH_ADDR` on an accepted beat that is not the last, set sticky `O_Err`=1 and go to NOTIFY (`O_Done` pulses).
  - The overflowing address is never issued.
  - `O_Err` clears on the next accepted `I_Ld.req`.
- `DMEM_AGU_WRAP_CHK_EN` undefined: addresses wrap modulo 2^`WIDTH_ADDR` silently, and `O_Err` is tied to 0.

## Structure
- Shared package `pkg_tpu` holds `dmem_t`, `address_t`, `s_ready_t`, `s_grant_t`, `fsm_extern_ld_t` and `WIDTH_SIZE_DMEM`. The block adds no new package types.
- No sub-module; a single flat module.

## Test plan
- Basic burst: base=0x010, stride=4, len=3, grant and ready always high -> addresses 0x010, 0x014, 0x018 at t+2..t+4; `O_Last` at t+4; `O_Done` at t+5.
- Stall and delayed grant: same descriptor, grant arrives 3 cycles late, ready low on the 2nd beat for 2 cycles -> address 0x014 held for 3 cycles; no skipped or duplicated beats; `O_Done` only once.
- Zero length: len=0 -> `O_Done` at t+1; `O_Arb_Req` and `O_Mem_Req` never high.
- Wrap:
  - base=0x3FC, stride=8, len=2 without the macro -> 0x3FC, 0x004, `O_Err`=0.
  - Same with the macro -> only 0x3FC is issued, `O_Err`=1, `O_Done` pulses.
- Ignored request and reset: a second req asserted in RUN is not captured. Asserting `reset`=0 mid-burst -> all outputs 0 immediately, no `O_Done`. A new req after release starts cleanly from its own base.
